// File: rtl/weight_loader_pkg.sv
// Shared layer definitions: loader FSM states and bank-size helpers, so the loader
// and the layer agree on frame length and word ordering (k = m + n*LENGHT_I).
package layer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic int n_w(input int lenght_i, input int lenght_o);
    return lenght_i * lenght_o;
  endfunction

  function automatic int cnt_w(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Serial weight stream with valid/ready framing and an end-of-frame marker.
interface weight_loader_if #(
  parameter int WIDTH_W = 9
);
  logic               s_valid;
  logic [WIDTH_W-1:0] s_data;
  logic               s_last;
  logic               s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_loader.sv
// Assembles a framed weight stream in a shadow bank and commits complete, well-framed
// sets to the layer's parallel weight bus with a one-cycle write strobe.
module weight_loader
  import layer_pkg::*;
#(
  parameter int LENGHT_I = 4,
  parameter int LENGHT_O = 2,
  parameter int WIDTH_W  = 9,
  parameter int N_W      = n_w(LENGHT_I, LENGHT_O),
  parameter int CNT_W    = cnt_w(N_W)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  weight_loader_if.slave                  s,
  output logic [N_W-1:0][WIDTH_W-1:0]     w_o,
  output logic                            wr,
  output logic                            busy,
  output logic                            err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);

  state_e                         state_r, state_nxt_s;
  logic [CNT_W-1:0]               cnt_r, cnt_nxt_s;
  logic [N_W-1:0][WIDTH_W-1:0]    shadow_r, shadow_nxt_s;
  logic                           wr_nxt_s, err_nxt_s;
  logic                           accept_s;

  assign s.s_ready = (state_r != COMMIT);
  assign busy      = (state_r != IDLE);
  assign accept_s  = s.s_valid && s.s_ready;

  // Next-state, counter, shadow write and strobe decode
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    shadow_nxt_s = shadow_r;
    wr_nxt_s     = 1'b0;
    err_nxt_s    = 1'b0;

    // cnt_r is 0 in IDLE, so the first word of a frame always lands in slot 0
    if (accept_s) begin
      shadow_nxt_s[cnt_r] = s.s_data;
    end else begin
      shadow_nxt_s = shadow_r;
    end

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (s.s_last) begin
            err_nxt_s = 1'b1;
          end else begin
            state_nxt_s = LOAD;
            cnt_nxt_s   = CNT_W'(1);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          if (cnt_r == CNT_LAST) begin
            if (s.s_last) begin
              state_nxt_s = COMMIT;
              wr_nxt_s    = 1'b1;
            end else begin
              state_nxt_s = IDLE;
              cnt_nxt_s   = '0;
              err_nxt_s   = 1'b1;
            end
          end else if (s.s_last) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            err_nxt_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = LOAD;
        end
      end
      COMMIT: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, shadow bank, committed bank and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      shadow_r <= '0;
      w_o      <= '0;
      wr       <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      shadow_r <= shadow_nxt_s;
      wr       <= wr_nxt_s;
      err      <= err_nxt_s;
      if (wr_nxt_s) begin
        w_o <= shadow_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scenario bench for weight_loader: committed banks are queued when a frame's final
// word is driven and checked against w_o whenever wr pulses.
module tb_weight_loader;
  import layer_pkg::*;

  localparam int NW = 8;
  localparam int WW = 9;
  typedef logic [NW-1:0][WW-1:0] bank_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  bank_t w_o;
  logic  wr, busy, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int wr_last = 0;
  int wr_prev = 0;
  bank_t sb_q[$];
  bank_t sb_exp;

  weight_loader_if #(.WIDTH_W(WW)) sif ();

  weight_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sif),
    .w_o   (w_o),
    .wr    (wr),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin
        wr_cnt++;
        wr_prev = wr_last;
        wr_last = cyc;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_wr: got wr=1 required no commit pending");
        end else begin
          sb_exp = sb_q.pop_front();
          if (w_o !== sb_exp) begin
            bad++;
            $display("FAIL sb_bank: got %h required %h", w_o, sb_exp);
          end
        end
      end
      if (err) err_cnt++;
      if (wr && err) begin
        total++;
        bad++;
        $display("FAIL wr_err_overlap: got wr=1 err=1 required not both");
      end
    end
  end

  task automatic put(input logic [WW-1:0] d, input logic last);
    int guard = 0;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    while (!sif.s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++;
      bad++;
      $display("FAIL put_timeout: got s_ready=0 required 1 within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
      sif.s_data  = WW'($urandom);
    end
  endtask

  task automatic check(input string name, input logic [WW*NW-1:0] got, input logic [WW*NW-1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic send_frame(input bank_t b, input logic last_ok, input bit push);
    if (push) sb_q.push_back(b);
    for (int k = 0; k < NW; k++) put(b[k], (k == NW - 1) ? last_ok : 1'b0);
  endtask

  task automatic test_reset();
    bank_t b;
    int w0;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_w_o", w_o, '0);
    check("reset_wr_err", {wr, err}, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < NW; k++) b[k] = WW'(100 + k);
    send_frame(b, 1'b1, 1'b1);
    idle(2);
    check("reset_pre_bank", w_o, b);
    w0 = wr_cnt;
    put(9'd5, 1'b0); put(9'd6, 1'b0); put(9'd7, 1'b0);
    @(negedge clk);
    sif.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_mid_w_o", w_o, '0);
    check("reset_mid_busy_wr_err", {busy, wr, err}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ready_busy", {sif.s_ready, busy}, 2'b10);
    idle(3);
    check("reset_no_wr", wr_cnt - w0, 0);
  endtask

  task automatic test_good();
    bank_t b;
    for (int k = 0; k < NW; k++) b[k] = WW'(k + 1);
    send_frame(b, 1'b1, 1'b1);
    @(negedge clk);
    sif.s_valid = 1'b0;
    check("good_commit_cycle", {wr, sif.s_ready, busy}, 3'b101);
    check("good_bank", w_o, b);
    @(negedge clk);
    check("good_after", {wr, busy}, 2'b00);
  endtask

  task automatic test_gapped();
    bank_t b;
    int g0, g1, g2, w0;
    for (int k = 0; k < NW; k++) b[k] = WW'(k + 1);
    g0 = $urandom_range(0, 6); g1 = $urandom_range(0, 6); g2 = $urandom_range(0, 6);
    w0 = wr_cnt;
    sb_q.push_back(b);
    for (int k = 0; k < NW; k++) begin
      put(b[k], (k == NW - 1) ? 1'b1 : 1'b0);
      if (k == g0) idle(1);
      if (k == g1) idle(1);
      if (k == g2) idle(1);
    end
    idle(3);
    check("gapped_wr_once", wr_cnt - w0, 1);
    check("gapped_bank", w_o, b);
  endtask

  task automatic test_short();
    bank_t prev;
    int w0, e0;
    prev = w_o;
    w0 = wr_cnt; e0 = err_cnt;
    for (int k = 0; k < 5; k++) put(WW'(50 + k), (k == 4) ? 1'b1 : 1'b0);
    @(negedge clk);
    sif.s_valid = 1'b0;
    check("short_err_pulse", {err, wr, busy}, 3'b100);
    @(negedge clk);
    check("short_err_drop", err, 1'b0);
    idle(2);
    check("short_counts", {wr_cnt - w0, err_cnt - e0}, {32'd0, 32'd1});
    check("short_bank_kept", w_o, prev);
  endtask

  task automatic test_long();
    bank_t prev, neg;
    int w0, e0;
    prev = w_o;
    w0 = wr_cnt; e0 = err_cnt;
    for (int k = 0; k < NW; k++) put(WW'(70 + k), 1'b0);
    @(negedge clk);
    sif.s_valid = 1'b0;
    check("long_err_pulse", {err, wr}, 2'b10);
    idle(2);
    check("long_counts", {wr_cnt - w0, err_cnt - e0}, {32'd0, 32'd1});
    check("long_bank_kept", w_o, prev);
    for (int k = 0; k < NW; k++) neg[k] = 9'h1FF;
    send_frame(neg, 1'b1, 1'b1);
    idle(2);
    check("long_neg_bank", w_o, neg);
  endtask

  task automatic test_back_to_back();
    bank_t a, b;
    int w0;
    for (int k = 0; k < NW; k++) begin
      a[k] = WW'(10 + k);
      b[k] = WW'(200 + 3 * k);
    end
    w0 = wr_cnt;
    send_frame(a, 1'b1, 1'b1);
    sb_q.push_back(b);
    @(negedge clk);
    sif.s_valid = 1'b1; sif.s_data = b[0]; sif.s_last = 1'b0;
    check("b2b_offer_in_commit", {wr, sif.s_ready}, 2'b10);
    @(negedge clk);
    check("b2b_ready_after", sif.s_ready, 1'b1);
    for (int k = 1; k < NW; k++) put(b[k], (k == NW - 1) ? 1'b1 : 1'b0);
    idle(3);
    check("b2b_two_wr", wr_cnt - w0, 2);
    check("b2b_period", wr_last - wr_prev, NW + 1);
    check("b2b_bank", w_o, b);
  endtask

  initial begin
    test_reset();
    test_good();
    test_gapped();
    test_short();
    test_long();
    test_back_to_back();
    idle(2);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
